// File: rtl/bc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bc_pkg
//  Description : Shared types and constants for the BC barcode line (tx/rx).
//  Revision    : 1.0
// ============================================================================
package bc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } bctx_state_t;

    localparam int NUM_BITS   = 8;
    localparam int BIT_IDX_W  = $clog2(NUM_BITS);
    localparam int MIN_PERIOD = 8;

endpackage : bc_pkg
`default_nettype wire

// File: rtl/bc_slot_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bc_slot_timer
//  Description : Per-slot cycle counter and registered low/high line phase.
//  Revision    : 1.0
// ============================================================================
module bc_slot_timer #(
    parameter int PERIOD_W = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                active,
    input  logic                last,
    input  logic [PERIOD_W-1:0] P,
    input  logic [PERIOD_W-1:0] L,
    output logic                line_low,
    output logic                slot_end
);

    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_inc;
    logic                r_low;
    logic                w_low_nxt;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign slot_end  = (r_cnt == (P - 1'b1));

    // r_low is kept one step ahead so that it always equals (cnt < L) for the
    // current cnt; every slot opens low because L is never zero once P >= 8.
    always_comb begin
        w_low_nxt = 1'b0;
        if (start) begin
            w_low_nxt = 1'b1;
        end else if (active) begin
            if (slot_end) begin
                w_low_nxt = !last;
            end else begin
                w_low_nxt = (w_cnt_inc < L);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_low <= 1'b0;
        end else begin
            if (start || slot_end || !active) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
            r_low <= w_low_nxt;
        end
    end

    assign line_low = r_low;

endmodule : bc_slot_timer
`default_nettype wire

// File: rtl/barcode_tx.sv
`default_nettype none
// ============================================================================
//  Module      : barcode_tx
//  Description : BC line generator: sync slot plus 8 pulse-width coded bits.
//  Revision    : 1.0
// ============================================================================
module barcode_tx #(
    parameter int PERIOD_W   = 22,
    parameter int MIN_PERIOD = bc_pkg::MIN_PERIOD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                send,
    input  logic [7:0]          tx_id,
    input  logic [PERIOD_W-1:0] period,
    output logic                BC,
    output logic                busy,
    output logic                done
);

    import bc_pkg::*;

    localparam logic [PERIOD_W-1:0]  c_min_period = PERIOD_W'(MIN_PERIOD);
    localparam logic [BIT_IDX_W-1:0] c_first_bit  = BIT_IDX_W'(NUM_BITS - 1);

    bctx_state_t           r_state;
    bctx_state_t           w_state_nxt;
    logic [BIT_IDX_W-1:0]  r_bit_idx;
    logic [7:0]            r_id;
    logic [PERIOD_W-1:0]   r_period;
    logic                  r_done;

    logic [PERIOD_W-1:0]   w_period_clamped;
    logic [PERIOD_W-1:0]   w_half;
    logic [PERIOD_W-1:0]   w_quarter;
    logic [PERIOD_W-1:0]   w_len;
    logic                  w_cur_bit;
    logic                  w_accept;
    logic                  w_active;
    logic                  w_last;
    logic                  w_done_nxt;
    logic                  w_slot_end;
    logic                  w_line_low;

    assign w_period_clamped = (period < c_min_period) ? c_min_period : period;
    assign w_half           = r_period >> 1;
    assign w_quarter        = r_period >> 2;
    assign w_cur_bit        = r_id[r_bit_idx];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (send)                                w_state_nxt = SYNC;
            SYNC: if (w_slot_end)                          w_state_nxt = DATA;
            DATA: if (w_slot_end && (r_bit_idx == '0))     w_state_nxt = IDLE;
            default:                                       w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept   = 1'b0;
        w_active   = 1'b0;
        w_last     = 1'b0;
        w_done_nxt = 1'b0;
        w_len      = w_half;
        case (r_state)
            IDLE: begin
                w_accept = send;
            end
            SYNC: begin
                w_active = 1'b1;
                w_len    = w_half;
            end
            DATA: begin
                w_active   = 1'b1;
                w_last     = (r_bit_idx == '0);
                w_len      = w_cur_bit ? w_quarter : (w_half + w_quarter);
                w_done_nxt = w_last && w_slot_end;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame latches, bit index, done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id      <= '0;
            r_period  <= '0;
            r_bit_idx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_id     <= tx_id;
                r_period <= w_period_clamped;
            end
            if (w_slot_end) begin
                if (r_state == SYNC) begin
                    r_bit_idx <= c_first_bit;
                end else if (r_state == DATA) begin
                    r_bit_idx <= r_bit_idx - 1'b1;
                end
            end
        end
    end

    bc_slot_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_accept),
        .active   (w_active),
        .last     (w_last),
        .P        (r_period),
        .L        (w_len),
        .line_low (w_line_low),
        .slot_end (w_slot_end)
    );

    // The line is the timer's phase flop; reset clears it, so BC idles high.
    assign BC   = ~w_line_low;
    assign busy = w_active;
    assign done = r_done;

endmodule : barcode_tx
`default_nettype wire

// File: tb/tb_barcode_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barcode_tx
//  Description : Self-checking bench for barcode_tx against a slot-rule model.
//  Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_barcode_tx;

    localparam int PW = 22;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          send   = 1'b0;
    logic [7:0]    tx_id  = 8'h00;
    logic [PW-1:0] period = '0;
    logic          BC;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    barcode_tx #(
        .PERIOD_W   (PW),
        .MIN_PERIOD (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .send   (send),
        .tx_id  (tx_id),
        .period (period),
        .BC     (BC),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: slot length clamps to 8; low part depends on slot kind.
    function automatic int eff_period(input int per);
        return (per < 8) ? 8 : per;
    endfunction

    function automatic int low_len(input logic [7:0] id, input int p, input int slot);
        if (slot == 0)      return p / 2;
        if (id[8 - slot])   return p / 4;
        return (p / 2) + (p / 4);
    endfunction

    task automatic start_frame(input logic [7:0] id, input int per);
        tx_id  = id;
        period = PW'(per);
        send   = 1'b1;
        tick();
        send   = 1'b0;
    endtask

    // Called in the first cycle of a frame; returns in the done cycle.
    task automatic check_frame(input logic [7:0] id, input int per_in,
                               input bit swap_id, input string name);
        int   p        = eff_period(per_in);
        int   n        = 9 * p;
        int   busy_cnt = 0;
        int   done_cnt = 0;
        int   bad      = 0;
        logic wave[$];
        for (int i = 0; i < n; i++) begin
            wave.push_back(BC);
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b0) done_cnt++;
            if (swap_id && i == 4 * p) tx_id = 8'h11;
            tick();
        end
        for (int i = 0; i < n; i++) begin
            if (wave[i] !== ((i % p) >= low_len(id, p, i / p))) bad++;
        end
        check({name, "_wave_errors"}, bad, 0);
        for (int s = 0; s < 9; s++) begin
            int w = 0;
            while (w < p && wave[s * p + w] === 1'b0) w++;
            check($sformatf("%s_slot%0d_low", name, s), w, low_len(id, p, s));
        end
        check({name, "_busy_cycles"}, busy_cnt, n);
        check({name, "_early_done"}, done_cnt, 0);
        check({name, "_done_end"}, done, 1);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_bc_end"}, BC, 1);
    endtask

    initial begin
        int idle_n;
        int glitch;
        int dn;
        logic [7:0] rid;
        int rper;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("rst_bc", BC, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();
        check("idle_bc", BC, 1);

        // Nominal frame, 64-cycle slots
        start_frame(8'h25, 64);
        check("t1_bc_falls", BC, 0);
        check_frame(8'h25, 64, 1'b0, "t1");
        tick();
        check("t1_done_one_cycle", done, 0);
        check("t1_bc_idle", BC, 1);

        // Short periods clamp to 8
        start_frame(8'hA5, 3);
        check_frame(8'hA5, 3, 1'b0, "t4");
        tick();
        start_frame(8'h0F, 0);
        check_frame(8'h0F, 0, 1'b0, "t4z");
        tick();

        // send held through the frame, ID changed mid-frame, back-to-back restart
        tx_id  = 8'h5A;
        period = PW'(16);
        send   = 1'b1;
        tick();
        check_frame(8'h5A, 16, 1'b1, "t3a");
        tick();
        send = 1'b0;
        check("t3b_bc_falls", BC, 0);
        check_frame(8'h11, 16, 1'b0, "t3b");

        // Random IDs/periods with random idle gaps (0 = back-to-back)
        for (int k = 0; k < 8; k++) begin
            idle_n = $urandom_range(0, 5);
            glitch = 0;
            for (int j = 0; j < idle_n; j++) begin
                tick();
                if (BC !== 1'b1 || busy !== 1'b0 || done !== 1'b0) glitch++;
            end
            check($sformatf("t6_idle%0d", k), glitch, 0);
            rid  = 8'($urandom);
            rper = $urandom_range(0, 40);
            start_frame(rid, rper);
            check_frame(rid, rper, 1'b0, $sformatf("t6f%0d", k));
        end
        tick();

        // Reset during bit 4 (ID C3 has a '0' there, so the line is low)
        start_frame(8'hC3, 20);
        for (int i = 0; i < 4 * 20 + 7; i++) tick();
        check("t5_pre_bc", BC, 0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_bc", BC, 1);
        check("t5_rst_busy", busy, 0);
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 1'b0) dn++;
        end
        rst_n = 1'b1;
        tick();
        if (done !== 1'b0) dn++;
        check("t5_no_done", dn, 0);
        start_frame(8'h3C, 24);
        check_frame(8'h3C, 24, 1'b0, "t5n");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_barcode_tx
`default_nettype wire
